// File: rtl/peg_prbs_byte_gen.sv
// Pseudo-random byte packet source: a 32-bit Fibonacci LFSR advanced 8 steps per byte,
// framed into packets of cfg_len bytes with a fixed idle gap and a ready/valid output.
module peg_prbs_byte_gen #(
    parameter int          LEN_W      = 16,
    parameter int          IFG_CYCLES = 4,
    parameter logic [31:0] DEF_SEED   = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_seed_load,
    input  logic [31:0]      cfg_seed,
    input  logic             cfg_start,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    output logic             done,
    output logic [15:0]      pkt_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_sop,
    output logic             out_eop
);

    localparam int GAP_W = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [15:0]        pkt_cnt_q, pkt_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_sop_q, out_sop_d;
    logic               out_eop_q, out_eop_d;

    logic [31:0]        lfsr_adv;
    logic               start_ok;
    logic               accept;
    logic [LEN_W-1:0]   idx_inc;

    function automatic logic [31:0] lfsr_adv8(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < 8; i++) begin
            t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
        end
        return t;
    endfunction

    assign lfsr_adv = lfsr_adv8(lfsr_q);
    // A seed load in the same cycle as a start wins; the start is dropped.
    assign start_ok = cfg_start && !cfg_seed_load && (cfg_len != '0);
    assign accept   = out_valid_q && out_ready;
    assign idx_inc  = idx_q + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: begin
                if (accept && out_eop_q) begin
                    state_d = (IFG_CYCLES == 0) ? ST_DONE : ST_GAP;
                end
            end
            ST_GAP:  if (gap_q <= GAP_W'(1)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    always_comb begin
        lfsr_d      = lfsr_q;
        len_d       = len_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        pkt_cnt_d   = pkt_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_seed_load) begin
                    lfsr_d = (cfg_seed == 32'd0) ? DEF_SEED : cfg_seed;
                end else if (start_ok) begin
                    len_d = cfg_len;
                    idx_d = '0;
                end
            end
            ST_LOAD: begin
                lfsr_d      = lfsr_adv;
                out_data_d  = lfsr_adv[7:0];
                out_valid_d = 1'b1;
                out_sop_d   = (idx_q == '0);
                out_eop_d   = (idx_q == len_q - LEN_W'(1));
            end
            ST_SEND: begin
                if (accept) begin
                    if (out_eop_q) begin
                        out_valid_d = 1'b0;
                        out_sop_d   = 1'b0;
                        out_eop_d   = 1'b0;
                        gap_d       = GAP_W'(IFG_CYCLES);
                    end else begin
                        // Present the next byte on the accepting edge for 1 byte/cycle.
                        idx_d      = idx_inc;
                        lfsr_d     = lfsr_adv;
                        out_data_d = lfsr_adv[7:0];
                        out_sop_d  = (idx_inc == '0);
                        out_eop_d  = (idx_inc == len_q - LEN_W'(1));
                    end
                end
            end
            ST_GAP:  gap_d = gap_q - GAP_W'(1);
            ST_DONE: pkt_cnt_d = pkt_cnt_q + 16'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q      <= DEF_SEED;
            len_q       <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            pkt_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            pkt_cnt_q   <= pkt_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;

endmodule

// File: tb/tb_peg_prbs_byte_gen.sv
// Bench for peg_prbs_byte_gen: packet table plus hand sequences, a software LFSR fills a
// scoreboard queue of expected beats that is checked against every presented byte.
module tb_peg_prbs_byte_gen;

    localparam int          LEN_W      = 16;
    localparam int          IFG_CYCLES = 4;
    localparam logic [31:0] DEF_SEED   = 32'h0000_0001;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_seed_load;
    logic [31:0]      cfg_seed;
    logic             cfg_start;
    logic [LEN_W-1:0] cfg_len;
    logic             busy;
    logic             done;
    logic [15:0]      pkt_cnt;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_sop;
    logic             out_eop;

    peg_prbs_byte_gen #(
        .LEN_W      (LEN_W),
        .IFG_CYCLES (IFG_CYCLES),
        .DEF_SEED   (DEF_SEED)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_seed_load (cfg_seed_load),
        .cfg_seed      (cfg_seed),
        .cfg_start     (cfg_start),
        .cfg_len       (cfg_len),
        .busy          (busy),
        .done          (done),
        .pkt_cnt       (pkt_cnt),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_sop       (out_sop),
        .out_eop       (out_eop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    typedef struct {
        bit          do_seed;
        logic [31:0] seed;
        int          len;
        logic [7:0]  rpat;
        bit          disturb;
        int          abort_after;
        bit          chk_first;
        logic [7:0]  exp_first;
        logic [15:0] exp_cnt;
    } vec_t;

    beat_t       sb[$];
    logic [31:0] m_lfsr;
    int          total = 0;
    int          bad   = 0;
    vec_t        tbl[0:8];

    function automatic logic [31:0] m_adv8(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < 8; i++) begin
            t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
        end
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_pkt(input vec_t v);
        int         beats;
        int         cyc;
        int         gap;
        bit         seen;
        logic [7:0] first_byte;
        beat_t      b;
        beats = 0;
        cyc = 0;
        gap = 0;
        seen = 1'b0;
        first_byte = 8'h00;
        if (v.do_seed) begin
            @(posedge clk); #1;
            cfg_seed_load = 1'b1;
            cfg_seed      = v.seed;
            @(posedge clk); #1;
            cfg_seed_load = 1'b0;
            m_lfsr = (v.seed == 32'd0) ? DEF_SEED : v.seed;
        end
        for (int i = 0; i < v.len; i++) begin
            m_lfsr = m_adv8(m_lfsr);
            b.d    = m_lfsr[7:0];
            b.sop  = (i == 0);
            b.eop  = (i == v.len - 1);
            sb.push_back(b);
        end
        @(posedge clk); #1;
        cfg_start = 1'b1;
        cfg_len   = 16'(v.len);
        @(posedge clk); #1;
        cfg_start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        while (beats < v.len && cyc < 300 && !(v.abort_after > 0 && beats == v.abort_after)) begin
            out_ready = v.rpat[cyc % 8];
            if (v.disturb && cyc == 3) begin
                cfg_start     = 1'b1;
                cfg_len       = 16'd2;
                cfg_seed_load = 1'b1;
                cfg_seed      = 32'h1234_5678;
            end
            if (v.disturb && cyc == 4) begin
                cfg_start     = 1'b0;
                cfg_seed_load = 1'b0;
            end
            @(negedge clk);
            if (cyc == 0) chk("load_cycle_valid", 32'(out_valid), 32'd0);
            if (cyc == 1) chk("first_valid_latency", 32'(out_valid), 32'd1);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_level", 32'(sb.size()), 32'd1);
                end else begin
                    chk("data", 32'(out_data), 32'(sb[0].d));
                    chk("sop", 32'(out_sop), 32'(sb[0].sop));
                    chk("eop", 32'(out_eop), 32'(sb[0].eop));
                    if (out_ready) begin
                        b = sb.pop_front();
                        if (beats == 0) first_byte = out_data;
                        beats++;
                    end
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        cfg_start     = 1'b0;
        cfg_seed_load = 1'b0;
        out_ready     = 1'b1;
        if (v.abort_after > 0) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_eop", 32'(out_eop), 32'd0);
            chk("rst_pkt_cnt", 32'(pkt_cnt), 32'(v.exp_cnt));
            sb.delete();
            m_lfsr = DEF_SEED;
        end else begin
            chk("beats", 32'(beats), 32'(v.len));
            for (int k = 0; k < 50 && !seen; k++) begin
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                end else begin
                    chk("gap_valid", 32'(out_valid), 32'd0);
                    gap++;
                end
            end
            chk("done_seen", 32'(seen), 32'd1);
            chk("gap_len", 32'(gap), 32'(IFG_CYCLES));
            @(negedge clk);
            chk("done_width", 32'(done), 32'd0);
            chk("idle_after_done", 32'(busy), 32'd0);
            chk("pkt_cnt", 32'(pkt_cnt), 32'(v.exp_cnt));
            chk("sb_drained", 32'(sb.size()), 32'd0);
            if (v.chk_first) chk("first_byte", 32'(first_byte), 32'(v.exp_first));
        end
        $display("pkt len=%0d ready_pat=%02h beats=%0d first=%02h pkt_cnt=%0d",
                 v.len, v.rpat, beats, first_byte, pkt_cnt);
    endtask

    initial begin
        vec_t hv;
        //            seed  seed_val        len  rpat   dist abort chk  first  cnt
        tbl[0] = '{1'b1, 32'h0000_0001,  1, 8'hFF, 1'b0, 0, 1'b1, 8'hB6, 16'd1};
        tbl[1] = '{1'b1, 32'h0000_0000,  4, 8'hFF, 1'b0, 0, 1'b1, 8'hB6, 16'd2};
        tbl[2] = '{1'b1, 32'h0000_0001,  8, 8'hFF, 1'b0, 0, 1'b1, 8'hB6, 16'd3};
        tbl[3] = '{1'b1, 32'h0000_0001,  8, 8'h49, 1'b0, 0, 1'b1, 8'hB6, 16'd4};
        tbl[4] = '{1'b0, 32'h0000_0000,  3, 8'hFF, 1'b0, 0, 1'b0, 8'h00, 16'd5};
        tbl[5] = '{1'b0, 32'h0000_0000,  6, 8'hFF, 1'b1, 0, 1'b0, 8'h00, 16'd6};
        tbl[6] = '{1'b1, 32'hDEAD_BEEF,  5, 8'h5A, 1'b0, 0, 1'b0, 8'h00, 16'd7};
        tbl[7] = '{1'b0, 32'h0000_0000, 10, 8'hFF, 1'b0, 2, 1'b0, 8'h00, 16'd0};
        tbl[8] = '{1'b0, 32'h0000_0000,  1, 8'hFF, 1'b0, 0, 1'b1, 8'hB6, 16'd1};

        rst           = 1'b1;
        cfg_seed_load = 1'b0;
        cfg_seed      = 32'd0;
        cfg_start     = 1'b0;
        cfg_len       = '0;
        out_ready     = 1'b1;
        m_lfsr        = DEF_SEED;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("reset_data", 32'(out_data), 32'd0);
        chk("reset_sop_eop", 32'({out_sop, out_eop}), 32'd0);

        for (int r = 0; r < 9; r++) begin
            run_pkt(tbl[r]);
        end

        // Zero-length start in IDLE must be ignored entirely.
        @(posedge clk); #1;
        cfg_start = 1'b1;
        cfg_len   = 16'd0;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("len0_busy", 32'(busy), 32'd0);
            chk("len0_done", 32'(done), 32'd0);
        end
        chk("len0_pkt_cnt", 32'(pkt_cnt), 32'd1);
        $display("len0 start ignored pkt_cnt=%0d", pkt_cnt);

        // Seed load together with start: seed taken, start dropped.
        @(posedge clk); #1;
        cfg_start     = 1'b1;
        cfg_len       = 16'd3;
        cfg_seed_load = 1'b1;
        cfg_seed      = 32'hCAFE_F00D;
        @(posedge clk); #1;
        cfg_start     = 1'b0;
        cfg_seed_load = 1'b0;
        m_lfsr        = 32'hCAFE_F00D;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("seed_start_busy", 32'(busy), 32'd0);
            chk("seed_start_valid", 32'(out_valid), 32'd0);
        end
        $display("seed+start same cycle: start ignored busy=%0d", busy);
        hv = '{1'b0, 32'h0, 2, 8'hFF, 1'b0, 0, 1'b0, 8'h00, 16'd2};
        run_pkt(hv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/peg_prbs_byte_gen.md
Name: peg_prbs_byte_gen

Overview:
- Hardware pseudo-random byte stream source. Framed as packets, ready/valid output.
- Serves as the synthesizable counterpart to the TB DPI-C byte randomiser. It feeds randomised payload into downstream datapath stages under test.
- The TB checker mirrors the LFSR below in software to predict every byte.

Parameters:
- LEN_W, 16: width of packet length and byte index.
- IFG_CYCLES, 4: idle cycles forced between packets (0 allowed).
- DEF_SEED, 32'h0000_0001: seed substituted when a zero seed is loaded.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_seed_load  in  1  pulse; load cfg_seed into LFSR.
- cfg_seed  in  32  LFSR seed.
- cfg_start  in  1  pulse; start one packet.
- cfg_len  in  LEN_W  packet length in bytes.
- busy  out  1  high from accepted start until gap complete.
- done  out  1  one-cycle pulse after gap of each packet.
- pkt_cnt  out  16  packets completed, wraps at 16'hFFFF->0.
- out_valid  out  1  byte available.
- out_ready  in  1  downstream accepts.
- out_data  out  8  byte.
- out_sop  out  1  first byte of packet, qualified by out_valid.
- out_eop  out  1  last byte of packet, qualified by out_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - LFSR = DEF_SEED.
  - State IDLE.
  - out_valid, out_sop, out_eop, busy, done = 0.
  - out_data = 0, pkt_cnt = 0.
  - Byte index and gap counter = 0.
- LFSR definition:
  - Fibonacci, 32 bits, s.
  - One step: f = s[31]^s[21]^s[1]^s[0]; s <= {s[30:0], f}.
  - Each byte advances 8 steps combinationally. The byte value is s[7:0] of the advanced state.
- Seed load:
  - When cfg_seed_load=1 and state IDLE, LFSR <= (cfg_seed==0) ? DEF_SEED : cfg_seed.
  - Ignored in any other state.
  - Seed load and start in the same cycle: the seed loads and the start is ignored.
- States:
  - IDLE
    - On cfg_start with cfg_len!=0 and no seed load: latch len, index=0, go LOAD.
    - cfg_start with cfg_len==0: ignored, no done pulse.
  - LOAD
    - Advance LFSR 8 steps.
    - out_data <= new s[7:0], out_valid <= 1, out_sop <= (index==0), out_eop <= (index==len-1).
    - Go SEND.
    - Latency from cfg_start to first out_valid = 2 cycles.
  - SEND
    - Hold out_data, out_sop, out_eop and out_valid stable while out_ready=0.
    - On out_valid&&out_ready, if not eop: index++, then present the next byte in the same edge (advance LFSR, update outputs, stay in SEND). This gives back-to-back bytes at 1 byte/cycle.
    - On accept with eop: out_valid <= 0, out_sop <= 0, out_eop <= 0. Gap counter = IFG_CYCLES; go GAP, or DONE if IFG_CYCLES==0.
  - GAP
    - Decrement each cycle; at 1 go DONE.
    - out_valid stays 0 for exactly IFG_CYCLES cycles after the eop accept.
  - DONE
    - done=1 for one cycle, pkt_cnt++ (wrapping), go IDLE.
- busy = (state != IDLE).
- cfg_start while busy: ignored; no queuing.
- len==1: out_sop and out_eop are both asserted on the single byte.
- The LFSR is not reseeded between packets; the stream continues across packets.
- The LFSR never reaches zero from a non-zero state.
- Reset mid-packet: outputs drop the next cycle. No eop is emitted. pkt_cnt returns to 0.

Test Plan:
- Reset, load seed 1, start len=1, ready=1 -> two cycles later one beat: data=8'hB6, sop=1, eop=1. LFSR=32'h0000_01B6. done pulses 4 gap cycles + 1 later; pkt_cnt=1.
- Seed 0 loaded then start len=4 -> identical bytes to seed 1. First byte 8'hB6. Bytes 2–4 match the TB software model. sop only on byte 1, eop only on byte 4.
- len=8, out_ready toggles 1,0,0,1,... -> data/sop/eop stable through stalls. Exactly 8 accepts, byte sequence identical to the ready=1 run.
- cfg_start pulsed during busy, cfg_len=0 in IDLE, and seed load during SEND -> all ignored. pkt_cnt increments only once per valid packet.
- Two packets len=3, IFG_CYCLES=4 -> exactly 4 cycles with out_valid=0 between eop accept and done, then done, then restart. Packet 2's bytes continue the LFSR sequence from packet 1.
- rst asserted at byte 3 of len=10 -> next cycle out_valid=0, busy=0, pkt_cnt=0, LFSR=DEF_SEED. A new start then yields first byte 8'hB6.
